// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - slot state and retirement record types for ibex_rvfi_gen
package ibex_pkg;

    typedef enum logic [1:0] {
        RVFI_EMPTY     = 2'd0,
        RVFI_WAIT_MEM  = 2'd1,
        RVFI_WAIT_NEXT = 2'd2
    } rvfi_gen_state_e;

    typedef struct packed {
        logic        trap;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
    } rvfi_rec_t;

    // RV32E only has x0..x15, so any address with bit 4 set is illegal there.
    function automatic logic reg_above_rv32e(input logic [4:0] addr);
        return addr[4];
    endfunction

endpackage

// File: rtl/ibex_rvfi_gen.sv
// rtl/ibex_rvfi_gen.sv - one-slot RVFI retirement record generator (optional IBEX_RVFI_GEN_MCYCLE_EN adds rvfi_ext_mcycle)
module ibex_rvfi_gen
    import ibex_pkg::*;
#(
    parameter bit RV32E = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        commit_valid_i,
    output logic        commit_ready_o,
    input  logic [31:0] commit_pc_i,
    input  logic [31:0] commit_insn_i,
    input  logic [4:0]  commit_rs1_addr_i,
    input  logic [4:0]  commit_rs2_addr_i,
    input  logic [4:0]  commit_rd_addr_i,
    input  logic [31:0] commit_rs1_rdata_i,
    input  logic [31:0] commit_rs2_rdata_i,
    input  logic [31:0] commit_rd_wdata_i,
    input  logic [31:0] commit_mem_addr_i,
    input  logic [31:0] commit_mem_wdata_i,
    input  logic [3:0]  commit_mem_rmask_i,
    input  logic [3:0]  commit_mem_wmask_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic [31:0] lsu_rd_wdata_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        rvfi_valid,
    output logic        rvfi_trap,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic [4:0]  rvfi_rs1_addr,
    output logic [4:0]  rvfi_rs2_addr,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rs1_rdata,
    output logic [31:0] rvfi_rs2_rdata,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_mem_addr,
    output logic [31:0] rvfi_mem_rdata,
    output logic [31:0] rvfi_mem_wdata,
    output logic [3:0]  rvfi_mem_rmask,
    output logic [3:0]  rvfi_mem_wmask
`ifdef IBEX_RVFI_GEN_MCYCLE_EN
    ,
    output logic [63:0] rvfi_ext_mcycle
`endif
);

    rvfi_gen_state_e state_q, state_d;
    rvfi_rec_t       slot_q, new_rec;
    logic [63:0]     order_q;
    logic            accept, emit, is_load, load_pending;

    assign accept       = commit_valid_i & commit_ready_o;
    assign emit         = (state_q == RVFI_WAIT_NEXT) & (accept | flush_i);
    assign is_load      = |commit_mem_rmask_i;
    assign load_pending = is_load & ~lsu_resp_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RVFI_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = load_pending ? RVFI_WAIT_MEM : RVFI_WAIT_NEXT;
        end else begin
            case (state_q)
                RVFI_WAIT_MEM:  if (lsu_resp_valid_i) state_d = RVFI_WAIT_NEXT;
                RVFI_WAIT_NEXT: if (flush_i)          state_d = RVFI_EMPTY;
                default:        state_d = state_q;
            endcase
        end
    end

    always_comb begin
        commit_ready_o = (state_q != RVFI_WAIT_MEM);
    end

    // A load whose response arrives with the commit is completed on the spot.
    always_comb begin
        new_rec           = '0;
        new_rec.insn      = commit_insn_i;
        new_rec.pc_rdata  = commit_pc_i;
        new_rec.rs1_addr  = commit_rs1_addr_i;
        new_rec.rs2_addr  = commit_rs2_addr_i;
        new_rec.rd_addr   = commit_rd_addr_i;
        new_rec.rs1_rdata = commit_rs1_rdata_i;
        new_rec.rs2_rdata = commit_rs2_rdata_i;
        new_rec.rd_wdata  = commit_rd_wdata_i;
        new_rec.mem_addr  = commit_mem_addr_i;
        new_rec.mem_wdata = commit_mem_wdata_i;
        new_rec.mem_rmask = commit_mem_rmask_i;
        new_rec.mem_wmask = commit_mem_wmask_i;
        if (is_load && lsu_resp_valid_i) begin
            new_rec.mem_rdata = lsu_rdata_i;
            new_rec.rd_wdata  = lsu_rd_wdata_i;
            if (lsu_resp_err_i) begin
                new_rec.trap    = 1'b1;
                new_rec.rd_addr = 5'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else if (accept) begin
            slot_q <= new_rec;
        end else if (state_q == RVFI_WAIT_MEM && lsu_resp_valid_i) begin
            slot_q.mem_rdata <= lsu_rdata_i;
            slot_q.rd_wdata  <= lsu_resp_err_i ? slot_q.rd_wdata : lsu_rd_wdata_i;
            if (lsu_resp_err_i) begin
                slot_q.trap    <= 1'b1;
                slot_q.rd_addr <= 5'd0;
                slot_q.rd_wdata <= lsu_rd_wdata_i;
            end
        end
    end

`ifdef IBEX_RVFI_GEN_MCYCLE_EN
    logic [63:0] mcycle_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle_q        <= '0;
            rvfi_ext_mcycle <= '0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            if (emit) rvfi_ext_mcycle <= mcycle_q;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            order_q        <= '0;
            rvfi_valid     <= 1'b0;
            rvfi_trap      <= 1'b0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
        end else begin
            rvfi_valid <= emit;
            if (emit) begin
                order_q        <= order_q + 64'd1;
                rvfi_order     <= order_q;
                rvfi_trap      <= slot_q.trap;
                rvfi_insn      <= slot_q.insn;
                rvfi_pc_rdata  <= slot_q.pc_rdata;
                rvfi_pc_wdata  <= flush_i ? flush_pc_i : commit_pc_i;
                rvfi_rs1_addr  <= slot_q.rs1_addr;
                rvfi_rs2_addr  <= slot_q.rs2_addr;
                rvfi_rd_addr   <= slot_q.rd_addr;
                rvfi_rs1_rdata <= slot_q.rs1_rdata;
                rvfi_rs2_rdata <= slot_q.rs2_rdata;
                rvfi_rd_wdata  <= slot_q.rd_wdata;
                rvfi_mem_addr  <= slot_q.mem_addr;
                rvfi_mem_rdata <= slot_q.mem_rdata;
                rvfi_mem_wdata <= slot_q.mem_wdata;
                rvfi_mem_rmask <= slot_q.mem_rmask;
                rvfi_mem_wmask <= slot_q.mem_wmask;
            end
        end
    end

    a_no_flush_in_wait_mem: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state_q == RVFI_WAIT_MEM && flush_i));

    a_rv32e_regs: assert property (@(posedge clk_i) disable iff (rst_i)
        !(RV32E && accept && (reg_above_rv32e(commit_rs1_addr_i) ||
                              reg_above_rv32e(commit_rs2_addr_i) ||
                              reg_above_rv32e(commit_rd_addr_i))));

endmodule

// File: tb/tb_ibex_rvfi_gen.sv
// tb/tb_ibex_rvfi_gen.sv - self-checking bench for ibex_rvfi_gen (IBEX_RVFI_GEN_MCYCLE_EN optional)
module tb_ibex_rvfi_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, commit_valid_i, commit_ready_o;
    logic [31:0] commit_pc_i, commit_insn_i;
    logic [4:0]  commit_rs1_addr_i, commit_rs2_addr_i, commit_rd_addr_i;
    logic [31:0] commit_rs1_rdata_i, commit_rs2_rdata_i, commit_rd_wdata_i;
    logic [31:0] commit_mem_addr_i, commit_mem_wdata_i;
    logic [3:0]  commit_mem_rmask_i, commit_mem_wmask_i;
    logic        lsu_resp_valid_i, lsu_resp_err_i;
    logic [31:0] lsu_rdata_i, lsu_rd_wdata_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        rvfi_valid, rvfi_trap;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
`ifdef IBEX_RVFI_GEN_MCYCLE_EN
    logic [63:0] rvfi_ext_mcycle;
`endif

    ibex_rvfi_gen dut (
        .clk_i(clk), .rst_i(rst_i),
        .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
        .commit_pc_i(commit_pc_i), .commit_insn_i(commit_insn_i),
        .commit_rs1_addr_i(commit_rs1_addr_i), .commit_rs2_addr_i(commit_rs2_addr_i),
        .commit_rd_addr_i(commit_rd_addr_i),
        .commit_rs1_rdata_i(commit_rs1_rdata_i), .commit_rs2_rdata_i(commit_rs2_rdata_i),
        .commit_rd_wdata_i(commit_rd_wdata_i),
        .commit_mem_addr_i(commit_mem_addr_i), .commit_mem_wdata_i(commit_mem_wdata_i),
        .commit_mem_rmask_i(commit_mem_rmask_i), .commit_mem_wmask_i(commit_mem_wmask_i),
        .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
        .lsu_rdata_i(lsu_rdata_i), .lsu_rd_wdata_i(lsu_rd_wdata_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask)
`ifdef IBEX_RVFI_GEN_MCYCLE_EN
        , .rvfi_ext_mcycle(rvfi_ext_mcycle)
`endif
    );

    typedef struct {
        bit          rst, cv, lv, lerr, flush;
        logic [31:0] pc, insn, rs1d, rs2d, rdw, maddr, mwdata, lrdata, lrdw, fpc;
        logic [4:0]  rs1a, rs2a, rda;
        logic [3:0]  rmask, wmask;
    } cyc_t;

    typedef struct {
        bit          valid, trap;
        logic [63:0] order, mcycle;
        logic [31:0] insn, pc_rdata, pc_wdata, rs1_rdata, rs2_rdata, rd_wdata;
        logic [31:0] mem_addr, mem_rdata, mem_wdata;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic [3:0]  rmask, wmask;
    } rec_t;

    typedef struct {
        cyc_t        in;
        bit          exp_valid;
        logic [63:0] exp_order;
        logic [31:0] exp_pcw;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: one held instruction, a flag for an outstanding load, an order count.
    bit          m_held, m_wait;
    rec_t        m_rec, m_last;
    logic [63:0] m_order, m_cycle;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic cyc_t idle();
        cyc_t c;
        c = '{default: '0};
        return c;
    endfunction

    function automatic cyc_t mk_commit(input logic [31:0] pc, input logic [3:0] rmask);
        cyc_t c;
        c = idle();
        c.cv = 1; c.pc = pc; c.insn = pc ^ 32'h0000_1013; c.rmask = rmask;
        c.rs1a = pc[6:2]; c.rs2a = 5'd2; c.rda = 5'd7;
        c.rs1d = pc + 32'd1; c.rs2d = pc + 32'd2; c.rdw = pc + 32'd3;
        c.maddr = pc + 32'h100; c.mwdata = ~pc;
        return c;
    endfunction

    function automatic cyc_t rnd_cyc();
        cyc_t c;
        c = idle();
        c.rst = ($urandom_range(99) == 0);
        c.cv = ($urandom_range(3) != 0);
        c.pc = $urandom; c.insn = $urandom; c.rs1d = $urandom; c.rs2d = $urandom;
        c.rdw = $urandom; c.maddr = $urandom; c.mwdata = $urandom;
        c.rs1a = 5'($urandom); c.rs2a = 5'($urandom); c.rda = 5'($urandom);
        c.rmask = ($urandom_range(1) == 0) ? 4'($urandom) : 4'h0;
        c.wmask = 4'($urandom);
        c.lv = ($urandom_range(2) == 0); c.lerr = ($urandom_range(4) == 0);
        c.lrdata = $urandom; c.lrdw = $urandom;
        c.flush = !m_wait && ($urandom_range(9) == 0);
        c.fpc = $urandom;
        return c;
    endfunction

    task automatic model(input cyc_t c);
        bit acc, emit;
        if (c.rst) begin
            m_held = 0; m_wait = 0; m_order = 0; m_cycle = 0;
            m_rec = '{default: '0}; m_last = '{default: '0};
            return;
        end
        acc  = c.cv && !m_wait;
        emit = m_held && !m_wait && (acc || c.flush);
        m_last.valid = emit;
        if (emit) begin
            m_last          = m_rec;
            m_last.valid    = 1;
            m_last.order    = m_order;
            m_last.pc_wdata = c.flush ? c.fpc : c.pc;
            m_last.mcycle   = m_cycle;
            m_order++;
        end
        if (m_wait && c.lv) begin
            m_wait = 0;
            m_rec.mem_rdata = c.lrdata;
            m_rec.rd_wdata  = c.lrdw;
            if (c.lerr) begin m_rec.trap = 1; m_rec.rd_addr = 0; end
        end
        if (acc) begin
            m_held = 1;
            m_rec = '{default: '0};
            m_rec.insn = c.insn; m_rec.pc_rdata = c.pc;
            m_rec.rs1_addr = c.rs1a; m_rec.rs2_addr = c.rs2a; m_rec.rd_addr = c.rda;
            m_rec.rs1_rdata = c.rs1d; m_rec.rs2_rdata = c.rs2d; m_rec.rd_wdata = c.rdw;
            m_rec.mem_addr = c.maddr; m_rec.mem_wdata = c.mwdata;
            m_rec.rmask = c.rmask; m_rec.wmask = c.wmask;
            if (c.rmask != 0) begin
                if (c.lv) begin
                    m_rec.mem_rdata = c.lrdata; m_rec.rd_wdata = c.lrdw;
                    if (c.lerr) begin m_rec.trap = 1; m_rec.rd_addr = 0; end
                end else begin
                    m_wait = 1;
                end
            end
        end else if (emit) begin
            m_held = 0;
        end
        m_cycle++;
    endtask

    task automatic check_outputs();
        chk("valid", 64'(rvfi_valid), 64'(m_last.valid));
        chk("order", rvfi_order, m_last.order);
        chk("trap", 64'(rvfi_trap), 64'(m_last.trap));
        chk("insn", 64'(rvfi_insn), 64'(m_last.insn));
        chk("pc_rdata", 64'(rvfi_pc_rdata), 64'(m_last.pc_rdata));
        chk("pc_wdata", 64'(rvfi_pc_wdata), 64'(m_last.pc_wdata));
        chk("rs1_addr", 64'(rvfi_rs1_addr), 64'(m_last.rs1_addr));
        chk("rs2_addr", 64'(rvfi_rs2_addr), 64'(m_last.rs2_addr));
        chk("rd_addr", 64'(rvfi_rd_addr), 64'(m_last.rd_addr));
        chk("rs1_rdata", 64'(rvfi_rs1_rdata), 64'(m_last.rs1_rdata));
        chk("rs2_rdata", 64'(rvfi_rs2_rdata), 64'(m_last.rs2_rdata));
        chk("rd_wdata", 64'(rvfi_rd_wdata), 64'(m_last.rd_wdata));
        chk("mem_addr", 64'(rvfi_mem_addr), 64'(m_last.mem_addr));
        chk("mem_rdata", 64'(rvfi_mem_rdata), 64'(m_last.mem_rdata));
        chk("mem_wdata", 64'(rvfi_mem_wdata), 64'(m_last.mem_wdata));
        chk("mem_rmask", 64'(rvfi_mem_rmask), 64'(m_last.rmask));
        chk("mem_wmask", 64'(rvfi_mem_wmask), 64'(m_last.wmask));
`ifdef IBEX_RVFI_GEN_MCYCLE_EN
        chk("mcycle", rvfi_ext_mcycle, m_last.mcycle);
`endif
    endtask

    // Inputs change 1 time unit after a rising edge; ready is sampled before the next edge.
    task automatic step(input cyc_t c);
        rst_i = c.rst; commit_valid_i = c.cv; commit_pc_i = c.pc; commit_insn_i = c.insn;
        commit_rs1_addr_i = c.rs1a; commit_rs2_addr_i = c.rs2a; commit_rd_addr_i = c.rda;
        commit_rs1_rdata_i = c.rs1d; commit_rs2_rdata_i = c.rs2d; commit_rd_wdata_i = c.rdw;
        commit_mem_addr_i = c.maddr; commit_mem_wdata_i = c.mwdata;
        commit_mem_rmask_i = c.rmask; commit_mem_wmask_i = c.wmask;
        lsu_resp_valid_i = c.lv; lsu_resp_err_i = c.lerr;
        lsu_rdata_i = c.lrdata; lsu_rd_wdata_i = c.lrdw;
        flush_i = c.flush; flush_pc_i = c.fpc;
        #1;
        if (!c.rst) chk("commit_ready", 64'(commit_ready_o), 64'(!m_wait));
        model(c);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    vec_t tbl[6];

    initial begin
        cyc_t c;
        rec_t seen;
        int   ready_low;

        m_held = 0; m_wait = 0; m_order = 0; m_cycle = 0;
        m_rec = '{default: '0}; m_last = '{default: '0};
        @(posedge clk);
        #1;

        // Back-to-back commits then a flush.
        c = idle(); c.rst = 1;
        tbl[0] = '{c, 0, 64'd0, 32'h0};
        tbl[1] = '{mk_commit(32'h80, 4'h0), 0, 64'd0, 32'h0};
        tbl[2] = '{mk_commit(32'h84, 4'h0), 1, 64'd0, 32'h84};
        tbl[3] = '{mk_commit(32'h88, 4'h0), 1, 64'd1, 32'h88};
        c = idle(); c.flush = 1; c.fpc = 32'h100;
        tbl[4] = '{c, 1, 64'd2, 32'h100};
        tbl[5] = '{idle(), 0, 64'd2, 32'h100};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].in);
            chk("tbl_valid", 64'(rvfi_valid), 64'(tbl[i].exp_valid));
            chk("tbl_order", rvfi_order, tbl[i].exp_order);
            chk("tbl_pc_wdata", 64'(rvfi_pc_wdata), 64'(tbl[i].exp_pcw));
        end

        // Load with a 3-cycle response while the next commit waits.
        c = idle(); c.rst = 1; step(c);
        step(mk_commit(32'h80, 4'hF));
        ready_low = 0;
        for (int i = 0; i < 3; i++) begin
            c = mk_commit(32'h84, 4'h0);
            if (i == 2) begin c.lv = 1; c.lrdata = 32'hDEADBEEF; c.lrdw = 32'hBEEF; end
            #1;
            if (commit_ready_o === 1'b0) ready_low++;
            #0;
            step(c);
        end
        chk("load_ready_low_cycles", 64'(ready_low), 64'd3);
        step(mk_commit(32'h84, 4'h0));
        chk("load_valid", 64'(rvfi_valid), 64'd1);
        chk("load_mem_rdata", 64'(rvfi_mem_rdata), 64'hDEADBEEF);
        chk("load_pc_rdata", 64'(rvfi_pc_rdata), 64'h80);

        // Load error then flush.
        c = idle(); c.rst = 1; step(c);
        step(mk_commit(32'h90, 4'hF));
        c = idle(); c.lv = 1; c.lerr = 1; c.lrdata = 32'h5555; step(c);
        c = idle(); c.flush = 1; c.fpc = 32'h1C0; step(c);
        chk("err_valid", 64'(rvfi_valid), 64'd1);
        chk("err_trap", 64'(rvfi_trap), 64'd1);
        chk("err_rd_addr", 64'(rvfi_rd_addr), 64'd0);
        chk("err_pc_wdata", 64'(rvfi_pc_wdata), 64'h1C0);

        // Commit with load response in the same cycle: no WAIT_MEM.
        c = idle(); c.rst = 1; step(c);
        c = mk_commit(32'hA0, 4'hF); c.lv = 1; c.lrdata = 32'h1234_5678; step(c);
        #1;
        chk("same_cycle_ready", 64'(commit_ready_o), 64'd1);
        step(mk_commit(32'hA4, 4'h0));
        chk("same_cycle_valid", 64'(rvfi_valid), 64'd1);
        chk("same_cycle_mem_rdata", 64'(rvfi_mem_rdata), 64'h1234_5678);

        // Reset during WAIT_MEM discards the held load.
        step(mk_commit(32'hB0, 4'hF));
        c = idle(); c.rst = 1; c.lv = 1; c.flush = 0; step(c);
        chk("rst_wait_valid", 64'(rvfi_valid), 64'd0);
        #1;
        chk("rst_first_ready", 64'(commit_ready_o), 64'd1);
        step(mk_commit(32'hC0, 4'h0));
        step(mk_commit(32'hC4, 4'h0));
        chk("rst_wait_rec_valid", 64'(rvfi_valid), 64'd1);
        chk("rst_wait_rec_order", rvfi_order, 64'd0);
        chk("rst_wait_rec_pc", 64'(rvfi_pc_rdata), 64'hC0);

`ifdef IBEX_RVFI_GEN_MCYCLE_EN
        c = idle(); c.rst = 1; step(c);
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc == 10 || cyc == 15) step(mk_commit(32'h200 + 32'(cyc), 4'h0));
            else step(idle());
        end
        chk("mcycle_first_record", rvfi_ext_mcycle, 64'd15);
`endif

        // Randomized traffic against the reference model.
        c = idle(); c.rst = 1; step(c);
        for (int i = 0; i < 3000; i++) step(rnd_cyc());

        seen = m_last;
        chk("random_order_progress", 64'(m_order >= 64'd0 && seen.order <= m_order), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
